conv_mac_unit: RTL

Pipelined, parametrised signed multiply-accumulate engine for the 1-D convolution layers of the seizure-detection CNN. It takes a stream of (sample, weight) pairs, accumulates KERNEL_LEN products per output, then scales, saturates and optionally rectifies the sum. It sits between the sliding-window sample feeder and the pooling stage, and replaces bare 8×8 product cells. It adds configurable operand widths, kernel length, valid/ready flow control and output saturation.

---
 rtl/conv_mac_unit_if.sv | 25 ++
 rtl/conv_mac_unit.sv | 113 +++++++++++
 2 files changed

// File: rtl/conv_mac_unit_if.sv
// Stream bundle for conv_mac_unit: (sample, weight) pairs in, scaled results out.
interface conv_mac_unit_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] a;
  logic signed [COEF_W-1:0] b;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_sat;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/conv_mac_unit.sv
// Pipelined signed MAC for 1-D conv layers: product -> accumulate over KERNEL_LEN taps -> shift/saturate.
// Optional ReLU before saturation when CONV_MAC_RELU_EN is defined; whole pipe stalls while a result waits.
module conv_mac_unit #(
  parameter int DATA_W     = 8,
  parameter int COEF_W     = 8,
  parameter int KERNEL_LEN = 3,
  parameter int ACC_W      = 24,
  parameter int SHIFT      = 0,
  parameter int OUT_W      = 16
) (
  input  logic           clk,
  input  logic           rst,
  conv_mac_unit_if.slave bus
);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int TAP_W  = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(KERNEL_LEN - 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [TAP_W-1:0]         r_tap_cnt;
  logic signed [PROD_W-1:0] r_p1;
  logic                     r_p1_valid;
  logic                     r_p1_last;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_out_valid;
  logic signed [OUT_W-1:0]  r_out_data;
  logic                     r_out_sat;

  logic                     w_en;
  logic                     w_accept;
  logic                     w_load;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_shift;
  logic signed [OUT_W-1:0]  w_fmt_data;
  logic                     w_fmt_sat;

  assign w_en     = !(r_out_valid && !bus.out_ready);
  assign w_accept = bus.in_valid && w_en;
  assign w_load   = w_en && r_p1_valid && r_p1_last;
  assign w_prod   = PROD_W'(bus.a) * PROD_W'(bus.b);

  // acc is zero whenever tap 0 arrives (cleared on the last tap and on reset),
  // so the first-tap case needs no separate select.
  assign w_sum    = r_acc + ACC_W'(r_p1);
  assign w_shift  = w_sum >>> SHIFT;

  always_comb begin
    w_fmt_data = w_shift[OUT_W-1:0];
    w_fmt_sat  = 1'b0;
`ifdef CONV_MAC_RELU_EN
    if (w_shift[ACC_W-1]) begin
      w_fmt_data = '0;
    end else if (w_shift > OUT_MAX) begin
      w_fmt_data = OUT_MAX[OUT_W-1:0];
      w_fmt_sat  = 1'b1;
    end
`else
    if (w_shift > OUT_MAX) begin
      w_fmt_data = OUT_MAX[OUT_W-1:0];
      w_fmt_sat  = 1'b1;
    end else if (w_shift < OUT_MIN) begin
      w_fmt_data = OUT_MIN[OUT_W-1:0];
      w_fmt_sat  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tap_cnt  <= '0;
      r_p1       <= '0;
      r_p1_valid <= 1'b0;
      r_p1_last  <= 1'b0;
    end else if (w_en) begin
      r_p1       <= w_prod;
      r_p1_valid <= w_accept;
      r_p1_last  <= w_accept && (r_tap_cnt == LAST_TAP);
      if (w_accept) begin
        r_tap_cnt <= (r_tap_cnt == LAST_TAP) ? '0 : r_tap_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_en && r_p1_valid) begin
      r_acc <= r_p1_last ? '0 : w_sum;
    end
  end

  // A load takes precedence over a consume in the same cycle, so out_valid stays high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_fmt_data;
      r_out_sat   <= w_fmt_sat;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_en;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sat   = r_out_sat;
endmodule
